// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider and its add_sub datapath unit.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package seq_divider_pkg;

    // Default operand/result width, shared with add_sub instances.
    localparam int DATA_WIDTH = 16;

    // Control FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done request bundle between a requester and seq_divider.
// Latency: none (wires only).
// Backpressure: start is only honoured while the divider is idle; no queueing.
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int nBit = DATA_WIDTH
);
    logic            start;
    logic [nBit-1:0] dividend;
    logic [nBit-1:0] divisor;
    logic            busy;
    logic            done;
    logic [nBit-1:0] quotient;
    logic [nBit-1:0] remainder;
    logic            div_by_zero;

    // Requester side: issues operands, observes status and results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_add_sub.sv
// Add/subtract unit: cond=1 gives a - b with cout=1 meaning no borrow (a >= b).
// Latency: combinational.
// Backpressure: none.
module add_sub
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cond,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH-1:0] b_eff;

    // Subtract is add of the ones' complement with carry-in set.
    assign b_eff = b ^ {WIDTH{cond}};

    // Single carry chain across the full width; carry-out is the no-borrow flag.
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cond};
endmodule

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// Latency: done nBit+1 cycles after the accepting edge; 1 cycle for divide-by-zero.
// Backpressure: start ignored (not queued) while in RUN or DONE.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int nBit = DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(nBit);

    state_t          state;
    state_t          state_nxt;

    // Working registers: Q shifts dividend bits out while quotient bits shift in.
    logic [nBit-1:0] q_reg;
    logic [nBit-1:0] r_reg;
    logic [nBit-1:0] d_reg;
    logic [CW-1:0]   count;

    // Result registers, held until a new result is produced.
    logic [nBit-1:0] quotient_reg;
    logic [nBit-1:0] remainder_reg;
    logic            dbz_reg;

    logic [nBit:0]   trial;
    logic [nBit:0]   diff;
    logic            cout;
    logic [nBit-1:0] r_next;
    logic [nBit-1:0] q_next;
    logic            divisor_zero;
    logic            last_step;
    logic            diff_msb_unused;

    // Trial value is the partial remainder with the next dividend bit appended.
    assign trial = {r_reg, q_reg[nBit-1]};

    add_sub #(
        .WIDTH (nBit + 1)
    ) u_add_sub (
        .a    (trial),
        .b    ({1'b0, d_reg}),
        .cond (1'b1),
        .sum  (diff),
        .cout (cout)
    );

    // When the subtraction succeeds the difference is below D, so its MSB is always 0.
    assign diff_msb_unused = diff[nBit];

    assign r_next       = cout ? diff[nBit-1:0] : trial[nBit-1:0];
    assign q_next       = {q_reg[nBit-2:0], cout};
    assign divisor_zero = (bus.divisor == '0);
    assign last_step    = (count == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: zero divisor short-circuits straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = divisor_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, iterate in RUN, publish on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg         <= '0;
            r_reg         <= '0;
            d_reg         <= '0;
            count         <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (divisor_zero) begin
                            quotient_reg  <= '1;
                            remainder_reg <= bus.dividend;
                            dbz_reg       <= 1'b1;
                        end else begin
                            q_reg <= bus.dividend;
                            r_reg <= '0;
                            d_reg <= bus.divisor;
                            count <= CW'(nBit - 1);
                        end
                    end
                end
                RUN: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    count <= count - 1'b1;
                    if (last_step) begin
                        quotient_reg  <= q_next;
                        remainder_reg <= r_next;
                        dbz_reg       <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: directed and random operations against a / and % reference.
// Latency: checks done timing at cycle 17 (normal) and cycle 1 (divide-by-zero).
// Backpressure: checks that start during RUN/DONE is dropped.
module tb_seq_divider;
    localparam int W = 16;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    seq_divider_if #(.nBit(W)) bus ();

    seq_divider #(.nBit(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run one operation from an idle divider and check timing and results.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int          done_cyc;
        int          busy_cnt;
        bit          busy_bad;
        int          exp_cyc;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
        logic        exp_z;
        exp_z   = (b == 0);
        exp_q   = exp_z ? {W{1'b1}} : a / b;
        exp_r   = exp_z ? a : a % b;
        exp_cyc = exp_z ? 1 : W + 1;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(negedge clk);
        // Operands change right after capture; the result must not follow them.
        bus.start = 1'b0; bus.dividend = W'($urandom); bus.divisor = W'($urandom);
        done_cyc = 0; busy_cnt = 0; busy_bad = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.busy !== ((!exp_z) && (k <= W))) busy_bad = 1'b1;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                done_cyc = k;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (done_cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_cyc, exp_cyc);
        end
        checks++;
        if (busy_bad || busy_cnt != (exp_z ? 0 : W)) begin
            errors++;
            $display("FAIL %s busy_window: got %0d busy cycles expected %0d", tag, busy_cnt, exp_z ? 0 : W);
        end
        checks++;
        if (bus.quotient !== exp_q || bus.remainder !== exp_r || bus.div_by_zero !== exp_z) begin
            errors++;
            $display("FAIL %s result: got q=%0d r=%0d z=%0b expected q=%0d r=%0d z=%0b",
                     tag, bus.quotient, bus.remainder, bus.div_by_zero, exp_q, exp_r, exp_z);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== exp_q ||
            bus.remainder !== exp_r || bus.div_by_zero !== exp_z) begin
            errors++;
            $display("FAIL %s hold_after_done: got done=%0b busy=%0b q=%0d r=%0d expected done=0 busy=0 q=%0d r=%0d",
                     tag, bus.done, bus.busy, bus.quotient, bus.remainder, exp_q, exp_r);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== '0 ||
            bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got busy=%0b done=%0b q=%0d r=%0d z=%0b expected all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_div(16'd100, 16'd7, "100_by_7");
        run_div(16'hFFFF, 16'h0001, "ffff_by_1");
        run_div(16'hFFFF, 16'hFFFF, "ffff_by_ffff");
        run_div(16'd3, 16'd10, "3_by_10");
        run_div(16'd0, 16'd5, "0_by_5");
        run_div(16'd5, 16'd0, "5_by_0");
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 12; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 3))
                0:       b = W'($urandom_range(0, 3));
                1:       b = W'($urandom_range(1, 255));
                default: b = W'($urandom);
            endcase
            run_div(a, b, $sformatf("random_%0d", i));
        end
    endtask

    // A new start during RUN and during the done cycle must be dropped.
    task automatic test_ignored_start();
        int done_cnt;
        int first_cyc;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;
        done_cnt = 0; first_cyc = 0;
        for (int k = 1; k <= 45; k++) begin
            bus.start = (k == 5) || (k == W + 1);
            if (k == 5) begin bus.dividend = 16'd9; bus.divisor = 16'd2; end
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (first_cyc == 0) begin
                    first_cyc = k;
                    checks++;
                    if (bus.quotient !== 16'd333 || bus.remainder !== 16'd1) begin
                        errors++;
                        $display("FAIL ignored_start result: got q=%0d r=%0d expected q=333 r=1",
                                 bus.quotient, bus.remainder);
                    end
                end
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        checks++;
        if (done_cnt != 1 || first_cyc != W + 1) begin
            errors++;
            $display("FAIL ignored_start done_pulses: got %0d pulses first at %0d expected 1 at %0d",
                     done_cnt, first_cyc, W + 1);
        end
    endtask

    // Start held high: accepted again the cycle after done, so one op per W+2 cycles.
    task automatic test_back_to_back();
        int cyc[$];
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd777; bus.divisor = 16'd10;
        @(negedge clk);
        for (int k = 1; k <= 2 * (W + 2) + 2; k++) begin
            if (bus.done === 1'b1) begin
                cyc.push_back(k);
                checks++;
                if (bus.quotient !== 16'd77 || bus.remainder !== 16'd7) begin
                    errors++;
                    $display("FAIL back_to_back result: got q=%0d r=%0d expected q=77 r=7",
                             bus.quotient, bus.remainder);
                end
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (W + 3) @(negedge clk);
        checks++;
        if (cyc.size() < 2 || cyc[0] != W + 1 || cyc[1] != 2 * W + 3) begin
            errors++;
            $display("FAIL back_to_back done_cycles: got %0d pulses first=%0d second=%0d expected %0d and %0d",
                     cyc.size(), cyc.size() > 0 ? cyc[0] : 0, cyc.size() > 1 ? cyc[1] : 0, W + 1, 2 * W + 3);
        end
    endtask

    // Reset mid-operation: abort, no done, outputs cleared, then a fresh op works.
    task automatic test_reset_abort();
        int done_seen;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;
        done_seen = 0;
        for (int k = 1; k < 8; k++) begin
            if (bus.done === 1'b1) done_seen++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== '0 ||
            bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort outputs: got busy=%0b done=%0b q=%0d r=%0d z=%0b expected all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        for (int k = 0; k < 25; k++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
            @(negedge clk);
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL reset_abort activity: got %0d active cycles expected 0", done_seen);
        end
        run_div(16'd50, 16'd6, "after_reset_50_by_6");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
